// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the receiver state encoding and the parity-mode constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received words.
// Head entry is read combinationally from registered storage.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_receiver.sv
// Asynchronous serial receiver with majority-voted sampling,
// configurable framing and a show-ahead word FIFO.
module uart_rx_fifo_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 432,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    input  logic                 rx_rd,
    input  logic                 err_clr,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int BW = clog2(DATA_BITS);
    localparam int FW = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_MODE = (PARITY == PAR_ODD);

    rx_state_e state, state_d;

    logic                 rx_meta;
    logic                 rxs;
    logic [1:0]           hist;
    logic                 maj;
    logic                 centre;
    logic [CW-1:0]        cnt, cnt_d;
    logic [BW-1:0]        bit_idx, bit_idx_d;
    logic                 stop_idx, stop_idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 par_err, par_err_d;
    logic                 frm_err, frm_err_d;
    logic                 push;
    logic [FW-1:0]        fifo_din;
    logic [FW-1:0]        fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 rd_fire;

    assign maj    = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
    assign centre = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            hist    <= 2'b11;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
            hist    <= {hist[0], rxs};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            stop_idx <= stop_idx_d;
            shreg    <= shreg_d;
            par_err  <= par_err_d;
            frm_err  <= frm_err_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt + CW'(1);
        bit_idx_d  = bit_idx;
        stop_idx_d = stop_idx;
        shreg_d    = shreg;
        par_err_d  = par_err;
        frm_err_d  = frm_err;
        push       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            ST_START: begin
                // Half a bit in: re-align the counter to bit centres.
                if (cnt == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = maj ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (centre) begin
                    cnt_d     = '0;
                    shreg_d   = {maj, shreg[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx + BW'(1);
                    if (bit_idx == BIT_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (centre) begin
                    cnt_d     = '0;
                    par_err_d = (^shreg) ^ maj ^ ODD_MODE;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (centre) begin
                    cnt_d     = '0;
                    frm_err_d = frm_err | ~maj;
                    if (stop_idx == STOP_LAST) begin
                        push    = 1'b1;
                        state_d = frm_err_d ? ST_WAIT_HIGH : ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo_din = {shreg, par_err, frm_err_d};
    assign rd_fire  = rx_rd && !fifo_empty;

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rx_rd),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A new overrun takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= (push && fifo_full && !rd_fire) ||
                          (rx_overrun && !err_clr);
        end
    end

    assign rx_valid = !fifo_empty;
    assign {rx_data, rx_parity_err, rx_frame_err} =
        fifo_empty ? '0 : fifo_dout;
    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_receiver.sv
// Randomised and directed bench for uart_rx_fifo_receiver
// against a frame-level model of received words.
module tb_uart_rx_fifo_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd   [4];
    logic       rd    [4];
    logic       clr   [4];
    logic       valid [4];
    logic [7:0] dat   [4];
    logic       perr  [4];
    logic       ferr  [4];
    logic       ovr   [4];
    logic       busy  [4];

    int n_chk = 0;
    int n_err = 0;

    logic [9:0] mq[$];
    logic       m_ovr = 1'b0;

    always #20 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_rx_fifo_receiver #(
            .CLKS_PER_BIT (g == 0 ? 432 : 16),
            .DATA_BITS    (8),
            .PARITY       (g == 2 ? 2 : (g == 3 ? 1 : 0)),
            .STOP_BITS    (g == 3 ? 2 : 1),
            .FIFO_DEPTH   (4)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .RxD           (rxd[g]),
            .rx_rd         (rd[g]),
            .err_clr       (clr[g]),
            .rx_valid      (valid[g]),
            .rx_data       (dat[g]),
            .rx_parity_err (perr[g]),
            .rx_frame_err  (ferr[g]),
            .rx_overrun    (ovr[g]),
            .rx_busy       (busy[g])
        );
    end

    function automatic int cpb(input int k);
        return (k == 0) ? 432 : 16;
    endfunction

    function automatic int par(input int k);
        return (k == 2) ? 2 : ((k == 3) ? 1 : 0);
    endfunction

    function automatic int nstop(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Parity bit that makes the frame correct for the instance's mode.
    function automatic logic good_par(input int k, input logic [7:0] d);
        return (par(k) == 2) ? ^d : ~(^d);
    endfunction

    function automatic logic [9:0] exp_word(input int k, input logic [7:0] d,
                                            input logic p, input logic s1,
                                            input logic s2);
        logic pe;
        logic fe;
        if (par(k) == 0) pe = 1'b0;
        else if (par(k) == 2) pe = (^d) ^ p;
        else pe = ~((^d) ^ p);
        fe = !s1 || (nstop(k) == 2 && !s2);
        return {d, pe, fe};
    endfunction

    task automatic model_push(input int k, input logic [7:0] d, input logic p,
                              input logic s1, input logic s2, input bit rd_same);
        if (rd_same && mq.size() > 0) void'(mq.pop_front());
        if (mq.size() < 4) mq.push_back(exp_word(k, d, p, s1, s2));
        else m_ovr = 1'b1;
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input logic p,
                              input logic s1, input logic s2);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (par(k) != 0) b.push_back(p);
        b.push_back(s1);
        if (nstop(k) == 2) b.push_back(s2);
        for (int i = 0; i < b.size(); i++) begin
            rxd[k] = b[i];
            repeat (cpb(k)) @(negedge clk);
        end
    endtask

    task automatic frame(input int k, input logic [7:0] d, input logic p,
                         input logic s1, input logic s2);
        model_push(k, d, p, s1, s2, 1'b0);
        send_frame(k, d, p, s1, s2);
    endtask

    task automatic idle(input int k, input int nb);
        rxd[k] = 1'b1;
        repeat (nb * cpb(k)) @(negedge clk);
    endtask

    task automatic drain(input int k);
        logic [9:0] w;
        while (mq.size() > 0) begin
            w = mq.pop_front();
            check("valid", valid[k], 1);
            check("data", dat[k], w[9:2]);
            check("perr", perr[k], w[1]);
            check("ferr", ferr[k], w[0]);
            rd[k] = 1'b1;
            @(negedge clk);
            rd[k] = 1'b0;
        end
        check("empty", valid[k], 0);
    endtask

    task automatic clear_ovr(input int k);
        clr[k] = 1'b1;
        @(negedge clk);
        clr[k] = 1'b0;
        m_ovr = 1'b0;
        check("ovr_clr", ovr[k], 0);
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int cnt_f;
        int gap;
        logic [7:0] d;
        logic p, s1, s2, last;

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rxd[i] = 1'b1;
            rd[i]  = 1'b0;
            clr[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_valid", valid[0], 0);
        check("rst_data", dat[0], 0);
        check("rst_perr", perr[0], 0);
        check("rst_ferr", ferr[0], 0);
        check("rst_ovr", ovr[0], 0);
        check("rst_busy", busy[0], 0);
        rst = 1'b0;

        // 8N1 single byte at the default bit period
        repeat (250) @(negedge clk);
        model_push(0, 8'hCD, 1'b0, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(0, 8'hCD, 1'b0, 1'b1, 1'b1);
            begin
                n = 0;
                while (!valid[0] && n < 6000) begin
                    @(negedge clk);
                    n++;
                end
                check("t1_latency", n, 3 + 216 + 9 * 432);
                check("t1_data", dat[0], 8'hCD);
            end
        join
        idle(0, 1);
        drain(0);
        check("t1_ovr", ovr[0], 0);

        // glitch shorter than half a bit
        rxd[0] = 1'b0;
        repeat (50) @(negedge clk);
        check("t2_busy", busy[0], 1);
        repeat (50) @(negedge clk);
        rxd[0] = 1'b1;
        n = 0;
        while (busy[0] && n < 216 + 3) begin
            @(negedge clk);
            n++;
        end
        check("t2_idle", busy[0], 0);
        repeat (432) @(negedge clk);
        check("t2_nopush", valid[0], 0);

        // even parity
        frame(2, 8'h58, 1'b0, 1'b1, 1'b1);
        frame(2, 8'h58, 1'b1, 1'b1, 1'b1);
        idle(2, 1);
        check("t3_perr_bad", perr[2], 1);
        drain(2);

        // break after a two-stop-bit frame
        model_push(3, 8'h33, good_par(3, 8'h33), 1'b1, 1'b0, 1'b0);
        send_frame(3, 8'h33, good_par(3, 8'h33), 1'b1, 1'b0);
        repeat (20 * 16) @(negedge clk);
        check("t4_busy", busy[3], 1);
        check("t4_ferr", ferr[3], 1);
        idle(3, 2);
        frame(3, 8'hA5, good_par(3, 8'hA5), 1'b1, 1'b1);
        idle(3, 1);
        drain(3);

        // overrun, then pop coinciding with the fifth push
        for (int i = 1; i <= 5; i++) frame(1, 8'(i), 1'b0, 1'b1, 1'b1);
        idle(1, 1);
        check("t5_ovr", ovr[1], 1);
        drain(1);
        check("t5_ovr_held", ovr[1], 1);
        clear_ovr(1);
        for (int i = 1; i <= 4; i++) frame(1, 8'(i), 1'b0, 1'b1, 1'b1);
        model_push(1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1);
        fork
            send_frame(1, 8'h05, 1'b0, 1'b1, 1'b1);
            begin
                repeat (2 + 8 + 9 * 16) @(negedge clk);
                rd[1] = 1'b1;
                @(negedge clk);
                rd[1] = 1'b0;
            end
        join
        idle(1, 1);
        check("t5_no_ovr", ovr[1], 0);
        drain(1);

        // reset during data bit 3
        frame(1, 8'h11, 1'b0, 1'b1, 1'b1);
        mq.delete();
        m_ovr = 1'b0;
        fork
            send_frame(1, 8'hF8, 1'b0, 1'b1, 1'b1);
            begin
                repeat (16 * 4 + 8) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("t6_valid", valid[1], 0);
                check("t6_data", dat[1], 0);
                check("t6_perr", perr[1], 0);
                check("t6_ferr", ferr[1], 0);
                check("t6_ovr", ovr[1], 0);
                check("t6_busy", busy[1], 0);
            end
        join
        idle(1, 1);
        frame(1, 8'h3C, 1'b0, 1'b1, 1'b1);
        idle(1, 1);
        drain(1);

        // random bursts on the fast instances
        for (int r = 0; r < 6; r++) begin
            k = 1 + (r % 3);
            cnt_f = $urandom_range(1, 6);
            for (int j = 0; j < cnt_f; j++) begin
                d  = 8'($urandom);
                p  = (par(k) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                s1 = ($urandom_range(0, 7) != 0);
                s2 = ($urandom_range(0, 7) != 0);
                frame(k, d, p, s1, s2);
                last = (nstop(k) == 2) ? s2 : s1;
                gap = $urandom_range(0, 2);
                if (!last && gap == 0) gap = 1;
                if (gap > 0) idle(k, gap);
            end
            idle(k, 1);
            check("rnd_ovr", ovr[k], m_ovr);
            drain(k);
            clear_ovr(k);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
